// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its memory/decode neighbours.
// The master modport is the fetch unit's side of the bus.
interface fetch_unit_if;
    logic        Start;
    logic [31:0] Instr;
    logic        InstrReady;
    logic        BranchEn;
    logic [31:0] BranchTarget;
    logic [31:0] ReadPC;
    logic [31:0] IR;
    logic [31:0] PCOut;
    logic        InstrValid;
    logic        Halted;
    logic        Fault;
    logic [31:0] InstrCount;

    modport master (
        input  Start, Instr, InstrReady, BranchEn, BranchTarget,
        output ReadPC, IR, PCOut, InstrValid, Halted, Fault, InstrCount
    );

    modport slave (
        output Start, Instr, InstrReady, BranchEn, BranchTarget,
        input  ReadPC, IR, PCOut, InstrValid, Halted, Fault, InstrCount
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/VALID/HALT sequencer with branch redirect and a valid/ready handshake to decode.
// Optional macro HALT_ON_ZERO_EN: a fetched all-zero word halts the unit instead of being delivered.
module fetch_unit #(
    parameter int unsigned MEM_WORDS = 30,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic          Clk,
    input  logic          Reset,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
    localparam logic [31:0] LAST_PC     = 32'(MEM_WORDS - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pcout_q, pcout_d;
    logic [31:0] count_q, count_d;
    logic        fault_q, fault_d;
    logic        valid_q, halted_q;

    logic        branch_ok_s;
    logic        branch_bad_s;
    logic        handshake_s;
    logic        zero_halt_s;
    logic [31:0] next_pc_s;

    assign branch_ok_s  = bus.BranchEn && (bus.BranchTarget <  MEM_WORDS_W);
    assign branch_bad_s = bus.BranchEn && (bus.BranchTarget >= MEM_WORDS_W);
    assign handshake_s  = (state_q == VALID) && bus.InstrReady;
    assign next_pc_s    = (pc_q == LAST_PC) ? 32'd0 : (pc_q + 32'd1);

`ifdef HALT_ON_ZERO_EN
    assign zero_halt_s = (bus.Instr == 32'h0000_0000);
`else
    assign zero_halt_s = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; a bad branch target wins over every other event
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FETCH, VALID: begin
                if (branch_bad_s) begin
                    state_d = HALT;
                end else if (branch_ok_s) begin
                    state_d = FETCH;
                end else if (state_q == FETCH) begin
                    state_d = zero_halt_s ? HALT : VALID;
                end else if (state_q == VALID) begin
                    state_d = bus.InstrReady ? FETCH : VALID;
                end else begin
                    state_d = bus.Start ? FETCH : IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: PC, captured instruction, count and fault flag
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcout_d = pcout_q;
        count_d = count_q;
        fault_d = fault_q;
        case (state_q)
            IDLE, FETCH, VALID: begin
                // An accepted instruction is counted even when a branch lands on the same edge
                if (handshake_s && !branch_bad_s) begin
                    count_d = count_q + 32'd1;
                end else begin
                    count_d = count_q;
                end
                if (branch_bad_s) begin
                    fault_d = 1'b1;
                end else if (branch_ok_s) begin
                    pc_d = bus.BranchTarget;
                end else if (state_q == FETCH) begin
                    ir_d    = zero_halt_s ? 32'd0 : bus.Instr;
                    pcout_d = pc_q;
                end else if (handshake_s) begin
                    pc_d = next_pc_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            HALT: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Datapath and status-flag registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            pcout_q  <= 32'd0;
            count_q  <= 32'd0;
            fault_q  <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pcout_q  <= pcout_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
            valid_q  <= (state_d == VALID);
            halted_q <= (state_d == HALT);
        end
    end

    assign bus.ReadPC     = pc_q;
    assign bus.IR         = ir_q;
    assign bus.PCOut      = pcout_q;
    assign bus.InstrCount = count_q;
    assign bus.Fault      = fault_q;
    assign bus.InstrValid = valid_q;
    assign bus.Halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table for the main fetch flow, scoreboard of accepted instructions,
// and hand-written sequences for wrap, branch, fault/halt and reset corners.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.MEM_WORDS(30), .RESET_PC(32'd0)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic [31:0] mem [0:29];
    assign bus.Instr = (bus.ReadPC < 32'd30) ? mem[bus.ReadPC[4:0]] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] ir; logic [31:0] pc; } exp_t;
    exp_t sb_q [$];

    typedef struct {
        logic        start;
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_halt;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] ir, input logic [31:0] pc);
        exp_t e;
        e.ir = ir;
        e.pc = pc;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%h/%h required=none", bus.IR, bus.PCOut);
        end else begin
            e = sb_q.pop_front();
            chk("sb_ir", bus.IR, e.ir);
            chk("sb_pcout", bus.PCOut, e.pc);
        end
    endtask

    task automatic tick();
        if (!rst && bus.InstrValid && bus.InstrReady) sb_check();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic start, input logic ready, input logic br, input logic [31:0] tgt);
        bus.Start        = start;
        bus.InstrReady   = ready;
        bus.BranchEn     = br;
        bus.BranchTarget = tgt;
    endtask

    task automatic chk_outs(input string name, input logic [31:0] pc, input logic valid,
                            input logic halted, input logic [31:0] cnt);
        chk({name, "_readpc"}, bus.ReadPC, pc);
        chk({name, "_valid"}, {31'd0, bus.InstrValid}, {31'd0, valid});
        chk({name, "_halted"}, {31'd0, bus.Halted}, {31'd0, halted});
        chk({name, "_count"}, bus.InstrCount, cnt);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk_outs(name, 32'd0, 1'b0, 1'b0, 32'd0);
        chk({name, "_ir"}, bus.IR, 32'd0);
        chk({name, "_pcout"}, bus.PCOut, 32'd0);
        chk({name, "_fault"}, {31'd0, bus.Fault}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 30; i++) begin
            if (i < 3)       mem[i] = 32'(i + 1) * 32'h11;
            else if (i == 3) mem[i] = 32'h0000_0000;
            else             mem[i] = 32'h1000 + 32'(i);
        end

        //        start ready br   tgt     readpc  valid halt  count
        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 1'b0, 1'b0, 32'd1};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 1'b1, 1'b0, 32'd1};
        for (int i = 4; i < 9; i++) begin
            vt[i] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 1'b0, 32'd1};
        end
        vt[9]  = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd2, 1'b0, 1'b0, 32'd2};
        vt[10] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd2, 1'b1, 1'b0, 32'd2};
        vt[11] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd3, 1'b0, 1'b0, 32'd3};

        drive(1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        tick();
        do_reset("reset");

        // Main flow: three instructions, a five-cycle stall on the second
        push_exp(32'h11, 32'd0);
        push_exp(32'h22, 32'd1);
        push_exp(32'h33, 32'd2);
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].start, vt[i].ready, vt[i].br, vt[i].tgt);
            tick();
            chk_outs($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_valid, vt[i].e_halt, vt[i].e_cnt);
        end

        // Zero instruction at PC 3
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
`ifdef HALT_ON_ZERO_EN
        chk_outs("zero_halt", 32'd3, 1'b0, 1'b1, 32'd3);
        chk("zero_halt_ir", bus.IR, 32'd0);
        chk("zero_halt_pcout", bus.PCOut, 32'd3);
        drive(1'b1, 1'b1, 1'b1, 32'd2);
        tick();
        chk_outs("zero_frozen", 32'd3, 1'b0, 1'b1, 32'd3);
`else
        chk_outs("zero_valid", 32'd3, 1'b1, 1'b0, 32'd3);
        push_exp(32'd0, 32'd3);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        chk_outs("zero_accept", 32'd4, 1'b0, 1'b0, 32'd4);
`endif

        // PC wrap from the last word back to 0
        do_reset("reset2");
        drive(1'b0, 1'b0, 1'b1, 32'd29);
        tick();
        chk_outs("wrap_br", 32'd29, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk_outs("wrap_v29", 32'd29, 1'b1, 1'b0, 32'd0);
        push_exp(mem[29], 32'd29);
        push_exp(32'h11, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        chk_outs("wrap_to0", 32'd0, 1'b0, 1'b0, 32'd1);
        tick();
        chk_outs("wrap_v0", 32'd0, 1'b1, 1'b0, 32'd1);
        tick();
        chk_outs("wrap_acc0", 32'd1, 1'b0, 1'b0, 32'd2);

        // Branch discards a held instruction; branch with handshake still counts
        do_reset("reset3");
        drive(1'b0, 1'b0, 1'b1, 32'd4);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk_outs("br_v4", 32'd4, 1'b1, 1'b0, 32'd0);
        chk("br_pcout4", bus.PCOut, 32'd4);
        drive(1'b0, 1'b0, 1'b1, 32'd10);
        tick();
        chk_outs("br_discard", 32'd10, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk_outs("br_v10", 32'd10, 1'b1, 1'b0, 32'd0);
        push_exp(mem[10], 32'd10);
        push_exp(mem[11], 32'd11);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        chk_outs("br_acc10", 32'd11, 1'b0, 1'b0, 32'd1);
        tick();
        chk_outs("br_v11", 32'd11, 1'b1, 1'b0, 32'd1);
        drive(1'b0, 1'b1, 1'b1, 32'd5);
        tick();
        chk_outs("br_hs", 32'd5, 1'b0, 1'b0, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk_outs("br_v5", 32'd5, 1'b1, 1'b0, 32'd2);
        chk("br_pcout5", bus.PCOut, 32'd5);

        // Out-of-range target: fault, halt, frozen until reset
        drive(1'b0, 1'b0, 1'b1, 32'd30);
        tick();
        chk_outs("fault", 32'd5, 1'b0, 1'b1, 32'd2);
        chk("fault_flag", {31'd0, bus.Fault}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outs($sformatf("frozen%0d", i), 32'd5, 1'b0, 1'b1, 32'd2);
            chk($sformatf("frozen%0d_pcout", i), bus.PCOut, 32'd5);
        end
        do_reset("fault_clr");

        // Reset beats a concurrent handshake and branch; Start needed afterwards
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk_outs("pre_rst_v", 32'd0, 1'b1, 1'b0, 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 32'd7);
        tick();
        rst = 1'b0;
        chk_outs("rst_conc", 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rst_conc_ir", bus.IR, 32'd0);
        chk("rst_conc_pcout", bus.PCOut, 32'd0);
        chk("rst_conc_fault", {31'd0, bus.Fault}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk_outs("idle_hold", 32'd0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk_outs("restart_v", 32'd0, 1'b1, 1'b0, 32'd0);
        chk("restart_ir", bus.IR, 32'h11);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
